// File: rtl/fios_pkg.sv
// Shared constants, address-map helpers and FSM encoding for the FIOS Montgomery multiplier.
package fios_pkg;

    localparam int unsigned DIGIT_W = 17;
    localparam int unsigned CARRY_W = 18;
    localparam int unsigned P_OFF   = 1;

    function automatic int unsigned calc_s(input int unsigned width);
        return (width + 1) / DIGIT_W + 1;
    endfunction

    function automatic int unsigned a_off(input int unsigned s);
        return s + 1;
    endfunction

    function automatic int unsigned b_off(input int unsigned s);
        return 2 * s + 1;
    endfunction

    function automatic int unsigned t_off(input int unsigned s);
        return 3 * s + 1;
    endfunction

    function automatic int unsigned ram_depth(input int unsigned s);
        return 4 * s + 3;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StLoadB,
        StCalcM,
        StInner,
        StShift,
        StSub,
        StWriteback,
        StDone
    } fios_state_e;

endpackage

// File: rtl/fios_bram.sv
// True dual-port 32-bit RAM: port A has byte enables and a clearable output register,
// port B is a plain word port; both have 1-cycle registered reads (read-first).
module fios_bram #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_en_i,
    input  logic [3:0]       a_we_i,
    input  logic [AddrW-1:0] a_addr_i,
    input  logic [31:0]      a_din_i,
    input  logic             a_clr_i,
    output logic [31:0]      a_dout_o,
    input  logic             b_we_i,
    input  logic [AddrW-1:0] b_addr_i,
    input  logic [31:0]      b_din_i,
    output logic [31:0]      b_dout_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] a_dout_q, a_dout_d;
    logic [31:0] b_dout_q;

    // Port A byte writes follow the port B write so a same-address collision resolves to A.
    always_ff @(posedge clk_i) begin
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_din_i;
        end
        if (a_en_i) begin
            for (int k = 0; k < 4; k++) begin
                if (a_we_i[k]) begin
                    mem_q[a_addr_i][8*k +: 8] <= a_din_i[8*k +: 8];
                end
            end
        end
        b_dout_q <= mem_q[b_addr_i];
    end

    always_comb begin
        a_dout_d = a_dout_q;
        if (a_clr_i) begin
            a_dout_d = '0;
        end else if (a_en_i) begin
            a_dout_d = mem_q[a_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_dout_q <= '0;
        end else begin
            a_dout_q <= a_dout_d;
        end
    end

    assign a_dout_o = a_dout_q;
    assign b_dout_o = b_dout_q;

endmodule

// File: rtl/fios_bram_top.sv
// FIOS Montgomery multiplier with an operand/result RAM; the running sum t lives in engine-local
// storage so each inner step costs one RAM read per cycle. FIOS_FINAL_SUB_EN adds a final
// conditional subtraction of p.
module fios_bram_top
    import fios_pkg::*;
#(
    parameter int unsigned WIDTH = 4096,
    parameter int unsigned S     = calc_s(WIDTH)
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    output logic        done_o,
    input  logic [31:0] BRAM_PORTA_i_addr,
    input  logic [31:0] BRAM_PORTA_i_din,
    input  logic [3:0]  BRAM_PORTA_i_we,
    input  logic        BRAM_PORTA_i_en,
    input  logic        BRAM_PORTA_i_rst,
    output logic [31:0] BRAM_PORTA_i_dout
);

    localparam int unsigned Depth = ram_depth(S);
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned IW    = $clog2(S + 1);
    localparam int unsigned TW    = $clog2(S);

    fios_state_e          state_q, state_d;
    logic                 ph_q, ph_d;
    logic [IW-1:0]        i_q, i_d, j_q, j_d;
    logic [DIGIT_W-1:0]   pinv_q, pinv_d, bi_q, bi_d, a_q, a_d, m_q, m_d;
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic [1:0]           top_q, top_d;

    logic [DIGIT_W-1:0]   t_mem [S];
    logic                 t_we;
    logic [TW-1:0]        t_waddr;
    logic [DIGIT_W-1:0]   t_wdata;
    logic [IW-1:0]        t_ridx;
    logic [DIGIT_W-1:0]   t_cur;

    logic [AW-1:0]        eb_addr;
    logic                 eb_we;
    logic [31:0]          eb_din, eb_dout;
    logic [DIGIT_W-1:0]   rd_dig;
    logic [DIGIT_W-1:0]   wb_dig;

    logic [35:0]          step_sum, m_seed;
    logic [33:0]          m_full;
    logic [18:0]          fold;

    logic [29:0]          a_idx;
    logic                 a_en;
    logic                 unused_bits;

`ifdef FIOS_FINAL_SUB_EN
    logic [DIGIT_W-1:0]   d_mem [S];
    logic                 d_we;
    logic [TW-1:0]        d_waddr;
    logic [DIGIT_W-1:0]   d_wdata;
    logic [DIGIT_W:0]     diff;
    logic                 bw_q, bw_d, use_d_q, use_d_d;
`endif

    assign rd_dig = eb_dout[DIGIT_W-1:0];
    assign a_idx  = BRAM_PORTA_i_addr[31:2];
    assign a_en   = BRAM_PORTA_i_en && (a_idx < 30'(Depth));

    fios_bram #(
        .Depth (Depth),
        .AddrW (AW)
    ) u_bram (
        .clk_i    (clock_i),
        .rst_ni   (reset_n_i),
        .a_en_i   (a_en),
        .a_we_i   (BRAM_PORTA_i_we),
        .a_addr_i (BRAM_PORTA_i_addr[AW+1:2]),
        .a_din_i  (BRAM_PORTA_i_din),
        .a_clr_i  (BRAM_PORTA_i_rst),
        .a_dout_o (BRAM_PORTA_i_dout),
        .b_we_i   (eb_we),
        .b_addr_i (eb_addr),
        .b_din_i  (eb_din),
        .b_dout_o (eb_dout)
    );

    // t reads as zero during the first outer iteration, so no clearing pass is needed.
    always_comb begin
        t_ridx = j_q;
        if (state_q inside {StInner, StShift, StSub}) begin
            t_ridx = j_q - IW'(1);
        end
        t_cur = '0;
        if (i_q != '0 && t_ridx < IW'(S)) begin
            t_cur = t_mem[t_ridx[TW-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        i_d     = i_q;
        j_d     = j_q;
        pinv_d  = pinv_q;
        bi_d    = bi_q;
        a_d     = a_q;
        m_d     = m_q;
        carry_d = carry_q;
        top_d   = top_q;
        eb_addr = '0;
        eb_we   = 1'b0;
        eb_din  = '0;
        t_we    = 1'b0;
        t_waddr = '0;
        t_wdata = '0;
        wb_dig  = t_cur;
`ifdef FIOS_FINAL_SUB_EN
        d_we    = 1'b0;
        d_waddr = '0;
        d_wdata = '0;
        bw_d    = bw_q;
        use_d_d = use_d_q;
        diff    = {1'b0, t_cur} - {1'b0, rd_dig} - (DIGIT_W+1)'(bw_q);
        if (use_d_q) begin
            wb_dig = d_mem[j_q[TW-1:0]];
        end
`endif
        step_sum = 36'(t_cur) + 36'(a_q) * 36'(bi_q) + 36'(m_q) * 36'(rd_dig) + 36'(carry_q);
        m_seed   = 36'(t_cur) + 36'(rd_dig) * 36'(bi_q);
        m_full   = 34'(m_seed[DIGIT_W-1:0]) * 34'(pinv_q);
        fold     = 19'(top_q) + 19'(carry_q);

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLoadB;
                    ph_d    = 1'b0;
                    i_d     = '0;
                    top_d   = '0;
                end
            end
            StLoadB: begin
                if (!ph_q) begin
                    eb_addr = '0;
                    ph_d    = 1'b1;
                end else begin
                    eb_addr = AW'(b_off(S)) + AW'(i_q);
                    pinv_d  = rd_dig;
                    j_d     = '0;
                    ph_d    = 1'b0;
                    state_d = StCalcM;
                end
            end
            StCalcM: begin
                if (!ph_q) begin
                    bi_d    = rd_dig;
                    eb_addr = AW'(a_off(S));
                    ph_d    = 1'b1;
                end else begin
                    m_d     = m_full[DIGIT_W-1:0];
                    carry_d = '0;
                    j_d     = '0;
                    ph_d    = 1'b0;
                    state_d = StInner;
                end
            end
            StInner: begin
                // Step j-1 completes in phase 0 as p_(j-1) arrives, overlapping the a_j fetch.
                if (!ph_q) begin
                    eb_addr = AW'(a_off(S)) + AW'(j_q);
                    if (j_q != '0) begin
                        carry_d = step_sum[34:17];
                        if (j_q != IW'(1)) begin
                            t_we    = 1'b1;
                            t_waddr = TW'(j_q - IW'(2));
                            t_wdata = step_sum[DIGIT_W-1:0];
                        end
                    end
                    ph_d = 1'b1;
                end else begin
                    a_d     = rd_dig;
                    eb_addr = AW'(P_OFF) + AW'(j_q);
                    j_d     = j_q + IW'(1);
                    ph_d    = 1'b0;
                    if (j_q == IW'(S - 1)) begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (!ph_q) begin
                    carry_d = step_sum[34:17];
                    t_we    = 1'b1;
                    t_waddr = TW'(j_q - IW'(2));
                    t_wdata = step_sum[DIGIT_W-1:0];
                    ph_d    = 1'b1;
                end else begin
                    t_we    = 1'b1;
                    t_waddr = TW'(S - 1);
                    t_wdata = fold[DIGIT_W-1:0];
                    top_d   = fold[18:17];
                    i_d     = i_q + IW'(1);
                    j_d     = '0;
                    ph_d    = 1'b0;
                    if (i_q == IW'(S - 1)) begin
`ifdef FIOS_FINAL_SUB_EN
                        bw_d    = 1'b0;
                        state_d = StSub;
`else
                        state_d = StWriteback;
`endif
                    end else begin
                        state_d = StLoadB;
                    end
                end
            end
`ifdef FIOS_FINAL_SUB_EN
            StSub: begin
                if (j_q != IW'(S)) begin
                    eb_addr = AW'(P_OFF) + AW'(j_q);
                    j_d     = j_q + IW'(1);
                end
                if (j_q != '0) begin
                    d_we    = 1'b1;
                    d_waddr = TW'(j_q - IW'(1));
                    d_wdata = diff[DIGIT_W-1:0];
                    bw_d    = diff[DIGIT_W];
                end
                if (j_q == IW'(S)) begin
                    use_d_d = !(diff[DIGIT_W] && top_q == '0);
                    j_d     = '0;
                    state_d = StWriteback;
                end
            end
`endif
            StWriteback: begin
                eb_we   = 1'b1;
                eb_addr = AW'(j_q);
                eb_din  = {15'b0, wb_dig};
                j_d     = j_q + IW'(1);
                if (j_q == IW'(S - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            ph_q    <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            pinv_q  <= '0;
            bi_q    <= '0;
            a_q     <= '0;
            m_q     <= '0;
            carry_q <= '0;
            top_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pinv_q  <= pinv_d;
            bi_q    <= bi_d;
            a_q     <= a_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            top_q   <= top_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (t_we) begin
            t_mem[t_waddr] <= t_wdata;
        end
    end

`ifdef FIOS_FINAL_SUB_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bw_q    <= 1'b0;
            use_d_q <= 1'b0;
        end else begin
            bw_q    <= bw_d;
            use_d_q <= use_d_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (d_we) begin
            d_mem[d_waddr] <= d_wdata;
        end
    end
`endif

    assign done_o = (state_q == StDone);

    assign unused_bits = ^{BRAM_PORTA_i_addr[1:0], eb_dout[31:17], step_sum[35],
                           m_seed[35:17], m_full[33:17]};

endmodule

// File: tb/tb_fios_bram_top.sv
// Directed bench for fios_bram_top at WIDTH=32 (S=2); a bit-serial Montgomery model feeds a
// scoreboard that is drained as results are read back.
module tb_fios_bram_top;
    import fios_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned S     = calc_s(WIDTH);
`ifdef FIOS_FINAL_SUB_EN
    localparam int unsigned BOUND = S * (2 * S + 6) + S + 8 + S + 2;
`else
    localparam int unsigned BOUND = S * (2 * S + 6) + S + 8;
`endif

    typedef struct {
        logic [63:0] exp;
        logic [63:0] p;
    } sb_t;

    logic        clk, rst_n, start, done;
    logic [31:0] addr, din, dout;
    logic [3:0]  we;
    logic        en, prst;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    fios_bram_top #(
        .WIDTH (WIDTH)
    ) dut (
        .clock_i           (clk),
        .reset_n_i         (rst_n),
        .start_i           (start),
        .done_o            (done),
        .BRAM_PORTA_i_addr (addr),
        .BRAM_PORTA_i_din  (din),
        .BRAM_PORTA_i_we   (we),
        .BRAM_PORTA_i_en   (en),
        .BRAM_PORTA_i_rst  (prst),
        .BRAM_PORTA_i_dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] p);
        logic [127:0] x;
        x = 128'(a) * 128'(b);
        for (int k = 0; k < 17 * S; k++) begin
            if (x[0]) x = x + 128'(p);
            x = x >> 1;
        end
        return 64'(x % 128'(p));
    endfunction

    function automatic logic [16:0] calc_pinv(input logic [63:0] p);
        logic [16:0] inv, pl;
        pl  = p[16:0];
        inv = pl;
        for (int k = 0; k < 5; k++) inv = inv * (17'd2 - pl * inv);
        return 17'd0 - inv;
    endfunction

    function automatic logic [31:0] digit(input logic [63:0] x, input int k);
        logic [63:0] sh;
        sh = x >> (17 * k);
        return {15'b0, sh[16:0]};
    endfunction

    task automatic write_word(input int idx, input logic [31:0] d, input logic [3:0] wmask);
        @(negedge clk);
        addr = 32'(idx) << 2;
        din  = d;
        we   = wmask;
        en   = 1'b1;
        @(negedge clk);
        we = 4'h0;
        en = 1'b0;
    endtask

    task automatic read_word(input int idx, output logic [31:0] d);
        @(negedge clk);
        addr = 32'(idx) << 2;
        we   = 4'h0;
        en   = 1'b1;
        @(negedge clk);
        d  = dout;
        en = 1'b0;
    endtask

    task automatic load(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                        input logic [16:0] pinv);
        sb_t e;
        write_word(0, {15'b0, pinv}, 4'hF);
        for (int k = 0; k < S; k++) begin
            write_word(1 + k, digit(p, k), 4'hF);
            write_word(S + 1 + k, digit(a, k), 4'hF);
            write_word(2 * S + 1 + k, digit(b, k), 4'hF);
        end
        e.exp = mont_ref(a, b, p);
        e.p   = p;
        sb_q.push_back(e);
    endtask

    task automatic run(input string tag, input int pulse_at, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_cleared"}, 64'(done), 64'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < int'(BOUND) + 4) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        check({tag, "_latency_ok"}, 64'(cyc <= int'(BOUND) && done === 1'b1), 64'd1);
    endtask

    task automatic check_result(input string tag, input bit expect_zero);
        logic [31:0] w;
        logic [63:0] res;
        sb_t e;
        res = '0;
        for (int k = 0; k < S; k++) begin
            read_word(k, w);
            check({tag, "_upper_zero"}, 64'(w[31:17]), 64'd0);
            if (expect_zero) check({tag, "_zero_word"}, 64'(w), 64'd0);
            res = res | (64'(w[16:0]) << (17 * k));
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_congruent"}, res % e.p, e.exp);
            check({tag, "_below_2p"}, 64'(res < 2 * e.p), 64'd1);
`ifdef FIOS_FINAL_SUB_EN
            check({tag, "_exact"}, res, e.exp);
`endif
        end
    endtask

    initial begin
        logic [63:0] p, a, b;
        logic [31:0] w;
        int          c1, c2;

        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        din   = '0;
        we    = '0;
        en    = 1'b0;
        prst  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dout", 64'(dout), 64'd0);
        rst_n = 1'b1;

        // Port A byte enables, hold and synchronous clear, on a scratch word.
        write_word(t_off(S), 32'hAAAA_AAAA, 4'hF);
        write_word(t_off(S), 32'h1234_5678, 4'b0101);
        read_word(t_off(S), w);
        check("byte_enable", 64'(w), 64'hAA34_AA78);
        @(negedge clk);
        check("dout_hold", 64'(dout), 64'hAA34_AA78);
        prst = 1'b1;
        @(negedge clk);
        prst = 1'b0;
        check("dout_clear", 64'(dout), 64'd0);

        // Toy case: 10*5*2^-34 mod 13 = 5.
        load(64'd13, 64'd10, 64'd5, 17'h1B13B);
        run("toy", 0, c1);
        check_result("toy", 1'b0);

        p = 64'($urandom | 32'h8000_0001);
        b = 64'($urandom) % p;
        load(p, 64'd0, b, calc_pinv(p));
        run("zero", 0, c1);
        check_result("zero", 1'b1);

        for (int n = 0; n < 3; n++) begin
            p = 64'($urandom | 32'h8000_0001);
            a = 64'($urandom) % p;
            b = 64'($urandom) % p;
            load(p, a, b, calc_pinv(p));
            run("rand", 0, c1);
            check_result("rand", 1'b0);
        end

        // Back-to-back: second start must drop done while it is still high.
        p = 64'($urandom | 32'h4000_0001);
        a = 64'($urandom) % p;
        b = 64'($urandom) % p;
        load(p, a, b, calc_pinv(p));
        run("b2b_first", 0, c1);
        check_result("b2b_first", 1'b0);
        p = 64'($urandom | 32'h2000_0001);
        a = 64'($urandom) % p;
        b = 64'($urandom) % p;
        load(p, a, b, calc_pinv(p));
        check("b2b_done_held", 64'(done), 64'd1);
        run("b2b_second", 0, c2);
        check_result("b2b_second", 1'b0);

        // A start pulse while busy must change neither result nor latency.
        p = 64'd4294967291;
        a = 64'd123456789;
        b = 64'd987654321;
        load(p, a, b, calc_pinv(p));
        run("ign_ref", 0, c1);
        check_result("ign_ref", 1'b0);
        load(p, a, b, calc_pinv(p));
        run("ign_pulse", 5, c2);
        check("ignored_start_time", 64'(c2), 64'(c1));
        check_result("ign_pulse", 1'b0);

        // Reset mid-computation, then restart on the untouched operands.
        p = 64'd3000000019;
        a = 64'd2222222221;
        b = 64'd1999999997;
        load(p, a, b, calc_pinv(p));
        read_word(b_off(S), w);
        check("pre_reset_dout", 64'(w), 64'(digit(b, 0)));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_dout", 64'(dout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < S; k++) begin
            read_word(b_off(S) + k, w);
            check("midreset_b_intact", 64'(w), 64'(digit(b, k)));
        end
        run("after_reset", 0, c1);
        check_result("after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
